// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes, RV32I major opcodes
// and the packed issue-entry record carried from decode to the ALU.
// No ports; imported by the decoder, the issue stage and anything driving the ALU.
package alu_issue_pkg;

  // ALU opcode is {funct7[5], funct3} so R-type instructions map straight through.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_t;

  localparam issue_t ISSUE_RST = '{a: 32'd0, b: 32'd0, op: ALU_ADD, rd: 5'd0,
                                   rd_we: 1'b0, illegal: 1'b0};

  // U-type immediate: upper 20 bits in place, low 12 cleared.
  function automatic logic [31:0] u_imm(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle between the fetch/regfile side, the issue stage and the ALU.
// Upstream: i_instr_vld/o_instr_rdy with instr, pc, rs1/rs2 data.
// Downstream: o_vld/i_rdy with operands, ALU opcode and writeback info.
interface alu_issue_if;
  logic        i_instr_vld;
  logic        o_instr_rdy;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        o_vld;
  logic        i_rdy;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic        o_illegal;

  // master: drives instructions in and consumes issued entries
  modport master (
    output i_instr_vld, i_instr, i_pc, i_rs1_data, i_rs2_data, i_rdy,
    input  o_instr_rdy, o_vld, o_alu_a, o_alu_b, o_alu_op, o_rd, o_rd_we, o_illegal
  );

  // slave: the issue stage itself
  modport slave (
    input  i_instr_vld, i_instr, i_pc, i_rs1_data, i_rs2_data, i_rdy,
    output o_instr_rdy, o_vld, o_alu_a, o_alu_b, o_alu_op, o_rd, o_rd_we, o_illegal
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Purpose: combinational RV32I decode of OP/OP-IMM/LUI/AUIPC into an issue entry.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: instr/pc/rs1_data/rs2_data in; dec (operands, opcode, rd, rd_we, illegal) out.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    dec         = ISSUE_RST;
    dec.rd      = instr[11:7];
    dec.illegal = 1'b1;
    // Opcode compare covers instr[1:0] == 2'b11 as well.
    case (opcode)
      OPC_OP: begin
        dec.a  = rs1_data;
        dec.b  = rs2_data;
        dec.op = {instr[30], funct3};
        dec.illegal = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.a       = rs1_data;
        dec.b       = imm_i;
        dec.op      = {1'b0, funct3};   // instr[30] ignored: there is no SUBI
        dec.illegal = 1'b0;
        if (funct3 == 3'b001) begin
          dec.b       = shamt;
          dec.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.b       = shamt;
          dec.op      = {instr[30], 3'b101};
          dec.illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
        end
      end
      OPC_LUI: begin
        dec.a       = 32'd0;
        dec.b       = u_imm(instr);
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a       = pc;
        dec.b       = u_imm(instr);
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
    // Illegal entries still issue, but with neutral operands and no writeback.
    if (dec.illegal) begin
      dec.a  = 32'd0;
      dec.b  = 32'd0;
      dec.op = ALU_ADD;
    end
    dec.rd_we = !dec.illegal && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// Purpose: execute-issue stage; decodes one instruction per accept and presents it to the ALU.
// Latency: 1 cycle accept-to-o_vld; back-to-back issue when i_rdy stays high.
// Backpressure: SKID=1 two-entry skid, o_instr_rdy = ~skid full (registered); SKID=0 rdy = ~o_vld | i_rdy.
// Ports: i_clk, i_rst (async, active-high), bus (alu_issue_if.slave) carrying both handshakes.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input logic       i_clk,
  input logic       i_rst,
  alu_issue_if.slave bus
);

  issue_t dec;
  issue_t main_q;
  issue_t skid_q;
  logic   main_vld;
  logic   skid_vld;
  logic   accept;
  logic   consume;

  alu_issue_dec u_dec (
    .instr    (bus.i_instr),
    .pc       (bus.i_pc),
    .rs1_data (bus.i_rs1_data),
    .rs2_data (bus.i_rs2_data),
    .dec      (dec)
  );

  assign accept  = bus.i_instr_vld & bus.o_instr_rdy;
  assign consume = main_vld & bus.i_rdy;

  // Main entry refills when empty or being consumed: skid first to keep order,
  // otherwise straight from the decoder.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_vld <= 1'b0;
      main_q   <= ISSUE_RST;
    end else if (!main_vld || consume) begin
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_q   <= skid_q;
      end else if (accept) begin
        main_vld <= 1'b1;
        main_q   <= dec;
      end else begin
        main_vld <= 1'b0;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      // An accept can only happen with the skid empty, so the skid either
      // catches an accept that the stalled main entry cannot take, or drains.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          skid_vld <= 1'b0;
          skid_q   <= ISSUE_RST;
        end else if (accept && main_vld && !consume) begin
          skid_vld <= 1'b1;
          skid_q   <= dec;
        end else if (consume) begin
          skid_vld <= 1'b0;
        end
      end
      assign bus.o_instr_rdy = ~skid_vld;
    end else begin : g_noskid
      assign skid_vld        = 1'b0;
      assign skid_q          = ISSUE_RST;
      assign bus.o_instr_rdy = ~main_vld | bus.i_rdy;
    end
  endgenerate

  assign bus.o_vld     = main_vld;
  assign bus.o_alu_a   = main_q.a;
  assign bus.o_alu_b   = main_q.b;
  assign bus.o_alu_op  = main_q.op;
  assign bus.o_rd      = main_q.rd;
  assign bus.o_rd_we   = main_q.rd_we;
  assign bus.o_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a driver pushes expected entries on accept,
// a monitor pops and compares on every o_vld & i_rdy, and checks payload hold.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue #(.SKID(1'b1)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  issue_t sb[$];
  int     checks   = 0;
  int     errors   = 0;
  int     issued   = 0;
  bit     rand_rdy = 1'b0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic issue_t cur_out();
    issue_t o;
    o = '{a: bus.o_alu_a, b: bus.o_alu_b, op: bus.o_alu_op, rd: bus.o_rd,
          rd_we: bus.o_rd_we, illegal: bus.o_illegal};
    return o;
  endfunction

  function automatic issue_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [4:0] rd, input logic we, input logic ill);
    issue_t e;
    e = '{a: a, b: b, op: op, rd: rd, rd_we: we, illegal: ill};
    return e;
  endfunction

  // Reference decode, written per named instruction.
  function automatic issue_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    issue_t      e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] simm;
    logic [31:0] sh;
    logic        ok;
    logic [3:0]  op;
    f7   = ins[31:25];
    f3   = ins[14:12];
    simm = 32'($signed(ins[31:20]));
    sh   = 32'(ins[24:20]);
    ok   = 1'b0;
    op   = ALU_ADD;
    e    = mk(32'd0, 32'd0, ALU_ADD, ins[11:7], 1'b0, 1'b1);
    case (ins[6:0])
      7'h33: begin
        ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: op = ALU_ADD;
          {7'h20, 3'd0}: op = ALU_SUB;
          {7'h00, 3'd1}: op = ALU_SLL;
          {7'h00, 3'd2}: op = ALU_SLT;
          {7'h00, 3'd3}: op = ALU_SLTU;
          {7'h00, 3'd4}: op = ALU_XOR;
          {7'h00, 3'd5}: op = ALU_SRL;
          {7'h20, 3'd5}: op = ALU_SRA;
          {7'h00, 3'd6}: op = ALU_OR;
          {7'h00, 3'd7}: op = ALU_AND;
          default: ok = 1'b0;
        endcase
        if (ok) begin e.a = r1; e.b = r2; e.op = op; e.illegal = 1'b0; end
      end
      7'h13: begin
        ok = 1'b1;
        e.b = simm;
        case (f3)
          3'd0: op = ALU_ADD;
          3'd2: op = ALU_SLT;
          3'd3: op = ALU_SLTU;
          3'd4: op = ALU_XOR;
          3'd6: op = ALU_OR;
          3'd7: op = ALU_AND;
          3'd1: begin op = ALU_SLL; e.b = sh; ok = (f7 == 7'h00); end
          default: begin
            e.b = sh;
            if (f7 == 7'h00) op = ALU_SRL;
            else if (f7 == 7'h20) op = ALU_SRA;
            else ok = 1'b0;
          end
        endcase
        if (ok) begin e.a = r1; e.op = op; e.illegal = 1'b0; end
        else e.b = 32'd0;
      end
      7'h37: begin e.a = 32'd0; e.b = ins & 32'hFFFF_F000; e.illegal = 1'b0; end
      7'h17: begin e.a = pc;    e.b = ins & 32'hFFFF_F000; e.illegal = 1'b0; end
      default: ;
    endcase
    e.rd_we = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [31:0] k;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    r   = $urandom;
    k   = $urandom_range(0, 99);
    f3  = r[14:12];
    imm = r[31:20];
    if (k < 45) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
      return {f7, r[24:20], r[19:15], f3, r[11:7], 7'h33};
    end else if (k < 90) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = r[1] ? 7'h20 : 7'h00;
      return {imm, r[19:15], f3, r[11:7], 7'h13};
    end else if (k < 95) begin
      return {r[31:12], r[11:7], r[2] ? 7'h37 : 7'h17};
    end else begin
      return {r[31:7], r[3] ? 7'h63 : 7'h30};
    end
  endfunction

  // Drive one instruction until accepted (bounded); push expectation at the accept edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input issue_t exp);
    bit acc;
    acc = 1'b0;
    bus.i_instr_vld = 1'b1;
    bus.i_instr     = ins;
    bus.i_pc        = pc;
    bus.i_rs1_data  = r1;
    bus.i_rs2_data  = r2;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (bus.o_instr_rdy) begin
        sb.push_back(exp);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr 0x%08h not accepted within 200 cycles", ins);
    end
    bus.i_instr_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random i_rdy toggling when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_rdy = ($urandom_range(0, 1) == 1);
  end

  // Monitor: compare on consume, check hold while stalled.
  initial begin
    bit     hold;
    issue_t held;
    issue_t got;
    issue_t exp;
    hold = 1'b0;
    held = ISSUE_RST;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        got = cur_out();
        if (hold) begin
          checks++;
          if (!bus.o_vld || got !== held) begin
            errors++;
            $display("FAIL hold_stable: vld=%0b got %h expected %h", bus.o_vld, got, held);
          end
        end
        if (bus.o_vld && bus.i_rdy) begin
          issued++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: got %h with empty scoreboard", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL issue_entry: a=%h b=%h op=%h rd=%0d we=%0b ill=%0b expected a=%h b=%h op=%h rd=%0d we=%0b ill=%0b",
                       got.a, got.b, got.op, got.rd, got.rd_we, got.illegal,
                       exp.a, exp.b, exp.op, exp.rd, exp.rd_we, exp.illegal);
            end
          end
        end
        hold = bus.o_vld && !bus.i_rdy;
        held = got;
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    bit          drained;
    bus.i_instr_vld = 1'b0;
    bus.i_instr     = 32'd0;
    bus.i_pc        = 32'd0;
    bus.i_rs1_data  = 32'd0;
    bus.i_rs2_data  = 32'd0;
    bus.i_rdy       = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check1("rst_vld",     32'(bus.o_vld), 32'd0);
    check1("rst_illegal", 32'(bus.o_illegal), 32'd0);
    check1("rst_rd_we",   32'(bus.o_rd_we), 32'd0);
    check1("rst_rd",      32'(bus.o_rd), 32'd0);
    check1("rst_a",       bus.o_alu_a, 32'd0);
    check1("rst_b",       bus.o_alu_b, 32'd0);
    check1("rst_op",      32'(bus.o_alu_op), 32'd0);
    check1("rst_instr_rdy", 32'(bus.o_instr_rdy), 32'd1);

    // Directed decodes with hand-computed expectations
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0));
    check1("add_latency_vld", 32'(bus.o_vld), 32'd1);
    send(32'h40415093, 32'h0, 32'h8000_0000, 32'd0, mk(32'h8000_0000, 32'd4, 4'b1101, 5'd1, 1'b1, 1'b0));
    send(32'h42415093, 32'h0, 32'h8000_0000, 32'd0, mk(32'd0, 32'd0, 4'b0000, 5'd1, 1'b0, 1'b1));
    send(32'h12345297, 32'h100, 32'd9, 32'd9, mk(32'h100, 32'h1234_5000, 4'b0000, 5'd5, 1'b1, 1'b0));
    send(32'hFFF00013, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd0, 1'b0, 1'b0));
    send(32'h4020_81B3, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'b1000, 5'd3, 1'b1, 1'b0));
    send(32'h0000_0000, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b1));
    idle(3);

    // Backpressure: two accepted, then stalled
    bus.i_rdy = 1'b0;
    idle(1);
    send(32'h00100093, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd1, 4'b0000, 5'd1, 1'b1, 1'b0));
    send(32'h00200113, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd2, 4'b0000, 5'd2, 1'b1, 1'b0));
    check1("bp_rdy_low", 32'(bus.o_instr_rdy), 32'd0);
    bus.i_instr_vld = 1'b1;
    bus.i_instr     = 32'hDEAD_BEEF;
    idle(3);
    check1("bp_rdy_still_low", 32'(bus.o_instr_rdy), 32'd0);
    bus.i_instr_vld = 1'b0;
    bus.i_rdy = 1'b1;
    send(32'h00300193, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd3, 4'b0000, 5'd3, 1'b1, 1'b0));
    send(32'h00400213, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd4, 4'b0000, 5'd4, 1'b1, 1'b0));
    idle(4);
    check1("bp_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset with both entries full
    bus.i_rdy = 1'b0;
    send(32'h00500293, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd5, 4'b0000, 5'd5, 1'b1, 1'b0));
    send(32'h00600313, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd6, 4'b0000, 5'd6, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check1("arst_vld_now", 32'(bus.o_vld), 32'd0);
    #3;
    rst = 1'b0;
    bus.i_rdy = 1'b1;
    idle(1);
    check1("arst_vld_after", 32'(bus.o_vld), 32'd0);
    check1("arst_rdy_after", 32'(bus.o_instr_rdy), 32'd1);
    idle(4);

    // Random traffic against the reference model
    issued   = 0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ins = gen_instr();
      pc  = {$urandom} & 32'hFFFF_FFFC;
      r1  = $urandom;
      r2  = $urandom;
      send(ins, pc, r1, r2, model(ins, pc, r1, r2));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_rdy = 1'b0;
    bus.i_rdy = 1'b1;
    drained = 1'b0;
    for (int t = 0; t < 100 && !drained; t++) begin
      idle(1);
      drained = (sb.size() == 0);
    end
    check1("rand_drained", 32'(sb.size()), 32'd0);
    check1("rand_issued", 32'(issued), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
